// File: rtl/i2c_slave_reg.sv
// rtl/i2c_slave_reg.sv - I2C responder translating bus transfers into register-file write/read strobes
module i2c_slave_reg #(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_REG_ADDR, S_ACK_REG,
        S_WDATA, S_ACK_WR, S_RDATA, S_MACK, S_WAIT_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [7:0]             shift_q, shift_d, ptr_q, ptr_d, wdata_q, wdata_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   rw_q, rw_d, we_q, we_d, re_q, re_d, rd_pend_q, rd_pend_d;
    logic                   sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, last_bit;
    logic [7:0]             byte_in;

    always_comb begin
        scl_sync_d[0] = scl_i;
        sda_sync_d[0] = sda_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync_d[i] = scl_sync_q[i-1];
            sda_sync_d[i] = sda_sync_q[i-1];
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_prev_d = scl_s;
    assign sda_prev_d = sda_s;
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_in    = {shift_q[6:0], sda_s};
    assign last_bit   = scl_rise && (cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q + {7'd0, we_q | re_q};
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        rd_pend_d = re_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        // Read data arrives the cycle after the strobe and becomes the outgoing byte
        if (rd_pend_q) shift_d = reg_rdata;

        if (start_det) begin
            state_d  = S_DEV_ADDR;
            cnt_d    = 3'd0;
            shift_d  = 8'h00;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            cnt_d    = 3'd0;
            shift_d  = 8'h00;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_REG_ADDR, S_WDATA: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                    end
                    if (last_bit) begin
                        if (state_q == S_DEV_ADDR) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = S_ACK_DEV;
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == S_REG_ADDR) begin
                            ptr_d   = byte_in;
                            state_d = S_ACK_REG;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = byte_in;
                            state_d = S_ACK_WR;
                        end
                    end
                end
                S_ACK_DEV, S_ACK_REG, S_ACK_WR: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                    if (scl_rise) begin
                        cnt_d = 3'd0;
                        if (state_q == S_ACK_DEV && rw_q) begin
                            re_d    = 1'b1;
                            state_d = S_RDATA;
                        end else if (state_q == S_ACK_DEV) begin
                            state_d = S_REG_ADDR;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) sda_oe_d = ~shift_q[7];
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_d = S_MACK;
                    end
                end
                S_MACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        cnt_d = 3'd0;
                        if (!sda_s) begin
                            re_d    = 1'b1;
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            wdata_q    <= 8'h00;
            cnt_q      <= 3'd0;
            rw_q       <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            rd_pend_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            we_q       <= we_d;
            re_q       <= re_d;
            rd_pend_q  <= rd_pend_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = ptr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;
endmodule
